// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : cpu_bus_pkg
//  Purpose   : Shared types and constants for the CPU memory-bus arbiter.
//  Revision  : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

    // Arbiter ownership / phase of the shared memory bus
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    // Word returned to the requester when the bus never acknowledges
    localparam logic [31:0] BUS_ERR_DATA    = 32'hDEAD_BEEF;

    // Default ack wait limit and the width of the wait counter
    localparam int          DEFAULT_TIMEOUT = 255;
    localparam int          TMO_CNT_W       = 8;

endpackage : cpu_bus_pkg
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface : mem_bus_arbiter_if
//  Purpose   : Fetch port, data port, memory bus and stall signals of the
//              memory-bus arbiter. "master" is the arbiter's view (it masters
//              the memory bus); "slave" is the environment's view (core ports
//              and the external memory/bridge).
//  Revision  : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch port
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic [DATA_W-1:0]     inst_rdata;
    logic                  inst_ready;
    // Data port
    logic                  data_req;
    logic                  data_wr;
    logic [DATA_W/8-1:0]   data_be;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic [DATA_W-1:0]     data_rdata;
    logic                  data_ready;
    // Memory bus
    logic                  mem_req;
    logic                  mem_wr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ack;
    // Hazard feedback
    logic                  stall_inst;
    logic                  stall_data;
    logic                  bus_err;

    modport master (
        input  inst_req, inst_addr,
        output inst_rdata, inst_ready,
        input  data_req, data_wr, data_be, data_addr, data_wdata,
        output data_rdata, data_ready,
        output mem_req, mem_wr, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output stall_inst, stall_data, bus_err
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_rdata, inst_ready,
        output data_req, data_wr, data_be, data_addr, data_wdata,
        input  data_rdata, data_ready,
        input  mem_req, mem_wr, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  stall_inst, stall_data, bus_err
    );

endinterface : mem_bus_arbiter_if
`default_nettype wire

// File: rtl/bus_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module    : bus_timeout_cnt
//  Purpose   : 8-bit ack-wait counter with clear, enable and saturation at
//              MAX; done is high while the count equals MAX.
//  Revision  : 1.0 - initial release
// ============================================================================
module bus_timeout_cnt
    import cpu_bus_pkg::*;
#(
    parameter int MAX = DEFAULT_TIMEOUT
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      done
);

    localparam logic [TMO_CNT_W-1:0] MAX_C = TMO_CNT_W'(MAX);

    logic [TMO_CNT_W-1:0] cnt_q;
    logic [TMO_CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at MAX
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + TMO_CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == MAX_C);

endmodule : bus_timeout_cnt
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : mem_bus_arbiter
//  Purpose   : Shares one multi-cycle memory bus between the fetch port and
//              the MEM-stage data port. Data has fixed priority because the
//              MEM stage holds the older instruction. Bus signals are
//              registered and latched at grant; readies pulse for one cycle.
//  Revision  : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_bus_arbiter_if.master  bus
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          state_q,      state_d;
    logic                mem_req_q,    mem_req_d;
    logic                mem_wr_q,     mem_wr_d;
    logic [BE_W-1:0]     mem_be_q,     mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic                inst_ready_q, inst_ready_d;
    logic                data_ready_q, data_ready_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic                bus_err_q,    bus_err_d;
    logic                cnt_clr;
    logic                cnt_en;
    logic                cnt_done;

    bus_timeout_cnt #(
        .MAX (TIMEOUT)
    ) u_tmo (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .done (cnt_done)
    );

    // Arbitration FSM next state and next values of all registered outputs
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_wr_d     = mem_wr_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        bus_err_d    = bus_err_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Data first: the MEM-stage instruction is older than fetch
                if (bus.data_req) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = bus.data_wr;
                    mem_be_d    = bus.data_wr ? bus.data_be : {BE_W{1'b1}};
                    mem_addr_d  = bus.data_addr;
                    mem_wdata_d = bus.data_wdata;
                    cnt_clr     = 1'b1;
                end else if (bus.inst_req) begin
                    state_d     = INST;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = 1'b0;
                    mem_be_d    = {BE_W{1'b1}};
                    mem_addr_d  = bus.inst_addr;
                    cnt_clr     = 1'b1;
                end
            end
            INST, DATA: begin
                cnt_en = 1'b1;
                if (bus.mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == INST) begin
                        inst_rdata_d = bus.mem_rdata;
                        inst_ready_d = 1'b1;
                    end else begin
                        // Writes leave the previous read word visible
                        if (!mem_wr_q) begin
                            data_rdata_d = bus.mem_rdata;
                        end
                        data_ready_d = 1'b1;
                    end
                end else if (cnt_done) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == INST) begin
                        inst_rdata_d = DATA_W'(BUS_ERR_DATA);
                        inst_ready_d = 1'b1;
                    end else begin
                        data_rdata_d = DATA_W'(BUS_ERR_DATA);
                        data_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                // Ready is high this cycle; no grant until the next IDLE
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.inst_ready = inst_ready_q;
    assign bus.data_ready = data_ready_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.stall_inst = bus.inst_req & ~inst_ready_q;
    assign bus.stall_data = bus.data_req & ~data_ready_q;

endmodule : mem_bus_arbiter
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : tb_mem_bus_arbiter
//  Purpose   : Directed self-checking bench for mem_bus_arbiter.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
    import cpu_bus_pkg::*;

    localparam int TMO = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait `dly` cycles after the grant, then acknowledge for one cycle
    task automatic do_ack(input int dly, input logic [31:0] rd);
        repeat (dly) tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        rst            = 1'b1;
        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_be    = '0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ack    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_mem_req",  bus.mem_req,    0);
        chk("rst_mem_addr", bus.mem_addr,   0);
        chk("rst_mem_be",   bus.mem_be,     0);
        chk("rst_bus_err",  bus.bus_err,    0);
        chk("rst_iready",   bus.inst_ready, 0);
        chk("rst_drdata",   bus.data_rdata, 0);

        // 1. Fetch read, ack two cycles after mem_req rises
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0040;
        tick();
        chk("t1_mem_req",  bus.mem_req,    1);
        chk("t1_mem_addr", bus.mem_addr,   32'h40);
        chk("t1_mem_be",   bus.mem_be,     4'hF);
        chk("t1_stall",    bus.stall_inst, 1);
        do_ack(2, 32'h2408_0005);
        chk("t1_iready",   bus.inst_ready, 1);
        chk("t1_irdata",   bus.inst_rdata, 32'h2408_0005);
        chk("t1_stall_rs", bus.stall_inst, 0);
        chk("t1_req_drop", bus.mem_req,    0);
        bus.inst_req = 1'b0;
        tick();
        chk("t1_ipulse",   bus.inst_ready, 0);

        // 2. Simultaneous fetch and data read: data first
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0080;
        bus.data_req  = 1'b1;
        bus.data_wr   = 1'b0;
        bus.data_addr = 32'h0000_0010;
        tick();
        chk("t2_mem_addr", bus.mem_addr,   32'h10);
        chk("t2_mem_wr",   bus.mem_wr,     0);
        chk("t2_stall_i",  bus.stall_inst, 1);
        chk("t2_stall_d",  bus.stall_data, 1);
        do_ack(0, 32'h1111_2222);
        chk("t2_dready",   bus.data_ready, 1);
        chk("t2_drdata",   bus.data_rdata, 32'h1111_2222);
        chk("t2_iready0",  bus.inst_ready, 0);
        bus.data_req = 1'b0;
        tick();
        chk("t2_idle_req", bus.mem_req,    0);
        tick();
        chk("t2_i_grant",  bus.mem_req,    1);
        chk("t2_i_addr",   bus.mem_addr,   32'h80);
        do_ack(1, 32'h3333_4444);
        chk("t2_iready",   bus.inst_ready, 1);
        chk("t2_irdata",   bus.inst_rdata, 32'h3333_4444);
        chk("t2_drd_hold", bus.data_rdata, 32'h1111_2222);
        bus.inst_req = 1'b0;
        tick();

        // 3. Data write
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_be    = 4'b0011;
        bus.data_addr  = 32'h0000_0020;
        bus.data_wdata = 32'hCAFE_F00D;
        tick();
        chk("t3_mem_wr",    bus.mem_wr,    1);
        chk("t3_mem_be",    bus.mem_be,    4'b0011);
        chk("t3_mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
        chk("t3_mem_addr",  bus.mem_addr,  32'h20);
        do_ack(0, 32'h5555_5555);
        chk("t3_dready",   bus.data_ready, 1);
        chk("t3_drdata",   bus.data_rdata, 32'h1111_2222);
        bus.data_req = 1'b0;
        bus.data_wr  = 1'b0;
        tick();
        chk("t3_dpulse",   bus.data_ready, 0);
        tick();

        // 6. Address change mid-transaction
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0100;
        tick();
        chk("t6_addr0",    bus.mem_addr,   32'h100);
        bus.inst_addr = 32'h0000_0200;
        tick();
        chk("t6_addr1",    bus.mem_addr,   32'h100);
        do_ack(1, 32'h0000_0077);
        chk("t6_iready",   bus.inst_ready, 1);
        chk("t6_irdata",   bus.inst_rdata, 32'h77);
        chk("t6_addr2",    bus.mem_addr,   32'h100);
        bus.inst_req = 1'b0;
        tick();

        // 4. Timeout on a data read: counter runs 0..TMO in DATA
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h0000_0030;
        tick();
        chk("t4_req_hi",   bus.mem_req,    1);
        n = 0;
        while (!bus.data_ready && n < 40) begin
            tick();
            n++;
        end
        chk("t4_latency",  n,              TMO + 1);
        chk("t4_dready",   bus.data_ready, 1);
        chk("t4_req_lo",   bus.mem_req,    0);
        chk("t4_drdata",   bus.data_rdata, 32'hDEAD_BEEF);
        chk("t4_bus_err",  bus.bus_err,    1);
        bus.data_req = 1'b0;
        tick();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0044;
        tick();
        do_ack(0, 32'h0BAD_CAFE);
        chk("t4_good_rd",  bus.inst_rdata, 32'h0BAD_CAFE);
        chk("t4_err_stk",  bus.bus_err,    1);
        bus.inst_req = 1'b0;
        tick();

        // 5. Reset while in DATA, stale ack afterwards
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h0000_0050;
        tick();
        tick();
        rst          = 1'b1;
        bus.data_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("t5_state",    dut.state_q,    IDLE);
        chk("t5_mem_req",  bus.mem_req,    0);
        chk("t5_mem_addr", bus.mem_addr,   0);
        chk("t5_bus_err",  bus.bus_err,    0);
        chk("t5_dready0",  bus.data_ready, 0);
        do_ack(0, 32'h9999_9999);
        chk("t5_dready1",  bus.data_ready, 0);
        chk("t5_drdata",   bus.data_rdata, 0);
        chk("t5_state2",   dut.state_q,    IDLE);
        tick();
        chk("t5_dready2",  bus.data_ready, 0);
        chk("t5_mem_req2", bus.mem_req,    0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_bus_arbiter
`default_nettype wire
